// File: rtl/gshare_pht.sv
// gshare_pht: 2-bit saturating counter pattern history table with init sequencer and write-first bypass
module gshare_pht #(
  parameter int G_WIDTH = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lookupValid,
  input  logic [G_WIDTH:0]   lookupIndex,
  output logic               predValid,
  output logic               predTaken,
  output logic [1:0]         predCounter,
  input  logic               updateValid,
  input  logic [G_WIDTH:0]   updateIndex,
  input  logic               updateTaken,
  output logic               ready
);
  localparam int DEPTH = 1 << (G_WIDTH + 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [1:0] pht [DEPTH];
  logic [G_WIDTH:0] init_ptr;
  logic [1:0] upd_old, upd_new, rd_val, wr_data;
  logic [G_WIDTH:0] wr_idx;
  logic wr_en;
  // Saturating next value for the trained entry, lookup bypass, and shared write port mux
  always_comb begin
    upd_old = pht[updateIndex];
    upd_new = updateTaken ? ((upd_old == 2'b11) ? 2'b11 : upd_old + 2'd1)
                          : ((upd_old == 2'b00) ? 2'b00 : upd_old - 2'd1);
    rd_val  = (updateValid && updateIndex == lookupIndex) ? upd_new : pht[lookupIndex];
    wr_en   = (state == INIT) || updateValid;
    wr_idx  = (state == INIT) ? init_ptr : updateIndex;
    wr_data = (state == INIT) ? 2'b01 : upd_new;
  end
  // Counter array: no reset, INIT rewrites every entry
  always_ff @(posedge clk)
    if (wr_en) pht[wr_idx] <= wr_data;
  // Init sequencer and registered prediction outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= INIT;
      init_ptr    <= '0;
      ready       <= 1'b0;
      predValid   <= 1'b0;
      predTaken   <= 1'b0;
      predCounter <= 2'b00;
    end else if (state == INIT) begin
      init_ptr  <= init_ptr + 1'b1;
      predValid <= 1'b0;
      if (init_ptr == '1) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end else begin
      predValid <= lookupValid;
      if (lookupValid) begin
        predCounter <= rd_val;
        predTaken   <= rd_val[1];
      end
    end
endmodule

// File: tb/tb_gshare_pht.sv
// tb_gshare_pht: randomized and directed scoreboard bench for gshare_pht against an array model
module tb_gshare_pht;
  localparam int DEPTH = 1024;
  logic clk = 0, reset = 1;
  logic lookupValid = 0, updateValid = 0, updateTaken = 0;
  logic [9:0] lookupIndex = 0, updateIndex = 0;
  logic predValid, predTaken, ready;
  logic [1:0] predCounter;
  int n_vec = 0, n_err = 0;
  int model [DEPTH];
  int exp_q [$];
  bit in_run = 0;

  gshare_pht #(.G_WIDTH(9)) dut (
    .clk(clk), .reset(reset), .lookupValid(lookupValid), .lookupIndex(lookupIndex),
    .predValid(predValid), .predTaken(predTaken), .predCounter(predCounter),
    .updateValid(updateValid), .updateIndex(updateIndex), .updateTaken(updateTaken),
    .ready(ready)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void train(int i, bit t);
    model[i] = t ? ((model[i] >= 3) ? 3 : model[i] + 1) : ((model[i] <= 0) ? 0 : model[i] - 1);
  endfunction

  always @(negedge clk)
    if (predValid) begin
      if (exp_q.size() == 0) chk("pred_unexpected", 1, 0);
      else begin
        int e;
        e = exp_q.pop_front();
        chk("pred_counter", predCounter, e);
        chk("pred_taken", predTaken, e >> 1);
      end
    end

  task automatic step(input bit lv, input int li, input bit uv, input int ui, input bit ut);
    lookupValid = lv; lookupIndex = li[9:0];
    updateValid = uv; updateIndex = ui[9:0]; updateTaken = ut;
    if (in_run) begin
      if (uv) train(ui, ut);
      if (lv) exp_q.push_back(model[li]);
    end
    @(posedge clk);
    #1;
    lookupValid = 0; updateValid = 0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2 reset = 1;
    in_run = 0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_pred_valid", predValid, 0);
    chk("rst_pred_counter", predCounter, 0);
    chk("rst_pred_taken", predTaken, 0);
    @(negedge clk);
    #2 reset = 0;
  endtask

  task automatic init_seq(input int stop_at);
    int bad_pv = 0;
    for (int e = 1; e <= stop_at; e++) begin
      step(1, 5, 1, 5, 1);
      if (predValid) bad_pv++;
      if (e == DEPTH - 1) chk("ready_before_last", ready, 0);
      if (e == DEPTH) chk("ready_after_last", ready, 1);
    end
    chk("init_pred_valid", bad_pv, 0);
    if (stop_at == DEPTH) begin
      for (int i = 0; i < DEPTH; i++) model[i] = 1;
      in_run = 1;
    end
  endtask

  initial begin
    int last;
    do_reset();
    init_seq(DEPTH);
    for (int i = 0; i < DEPTH; i++) step(1, i, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("idx5_after_init_drops", model[5], 1);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 'h155, 1);
    step(1, 'h155, 0, 0, 0);
    chk("sat_up_counter", predCounter, 3);
    chk("sat_up_taken", predTaken, 1);
    step(0, 0, 1, 'h155, 1);
    step(1, 'h155, 0, 0, 0);
    chk("sat_hold_11", predCounter, 3);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 'h155, 0);
    step(1, 'h155, 0, 0, 0);
    chk("sat_down_counter", predCounter, 0);
    step(0, 0, 1, 'h155, 0);
    step(1, 'h155, 0, 0, 0);
    chk("sat_hold_00", predCounter, 0);
    step(1, 'h0AA, 1, 'h0AA, 1);
    chk("bypass_counter", predCounter, 2);
    chk("bypass_taken", predTaken, 1);
    step(0, 0, 1, 'h0AA, 0);
    step(1, 'h0AA, 1, 'h0AB, 1);
    chk("no_bypass_counter", predCounter, 1);
    do_reset();
    init_seq(500);
    do_reset();
    init_seq(DEPTH);
    step(0, 0, 1, 3, 1);
    step(0, 0, 1, 3, 1);
    step(1, 3, 0, 0, 0);
    chk("idx3_trained", predCounter, 3);
    do_reset();
    init_seq(DEPTH);
    step(1, 3, 0, 0, 0);
    chk("idx3_after_reinit", predCounter, 1);
    step(0, 0, 1, 2, 1);
    step(0, 0, 1, 2, 1);
    step(1, 1, 0, 0, 0);
    chk("b2b_valid_1", predValid, 1);
    step(1, 2, 0, 0, 0);
    chk("b2b_valid_2", predValid, 1);
    step(1, 3, 0, 0, 0);
    chk("b2b_valid_3", predValid, 1);
    last = model[3];
    step(0, 0, 0, 0, 0);
    chk("b2b_valid_drop", predValid, 0);
    chk("b2b_counter_hold", predCounter, last);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 1));
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
